// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the spectral peak finder.
package fft_pkg;

  localparam int N_BINS = 1024;
  localparam int DW     = 16;
  localparam int MAG_W  = 32;
  localparam int BIN_W  = 10;

  typedef logic [MAG_W-1:0] mag_t;
  typedef logic [BIN_W-1:0] bin_t;

  typedef enum logic {IDLE, RUN} peak_state_t;

  function automatic logic inWindow(input bin_t b, input int lo, input int hi);
    return (int'(b) >= lo) && (int'(b) <= hi);
  endfunction

endpackage

// File: rtl/fft_peak_finder_if.sv
// Bin-pair input stream from dft_top and the published peak result.
interface fft_peak_finder_if #(
  parameter int DW = 16
);
  import fft_pkg::*;

  logic                 next_out;
  logic signed [DW-1:0] real0;
  logic signed [DW-1:0] imag0;
  logic signed [DW-1:0] real1;
  logic signed [DW-1:0] imag1;
  bin_t                 peak_bin;
  mag_t                 peak_mag;
  logic                 peak_valid;
  logic                 frame_abort;

  modport master (
    output next_out, real0, imag0, real1, imag1,
    input  peak_bin, peak_mag, peak_valid, frame_abort
  );

  modport slave (
    input  next_out, real0, imag0, real1, imag1,
    output peak_bin, peak_mag, peak_valid, frame_abort
  );

endinterface

// File: rtl/cmag_sq.sv
// Complex magnitude squared: squares are registered, the unsigned sum follows them.
module cmag_sq
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] re,
  input  logic signed [W-1:0] im,
  output mag_t                mag
);

  logic signed [2*W-1:0] r_reSq;
  logic signed [2*W-1:0] r_imSq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reSq <= '0;
      r_imSq <= '0;
    end else begin
      r_reSq <= re * re;
      r_imSq <= im * im;
    end
  end

  // Each square is non-negative and at most 2^30, so the 32-bit sum cannot wrap.
  assign mag = mag_t'($unsigned(r_reSq)) + mag_t'($unsigned(r_imSq));

endmodule

// File: rtl/fft_peak_finder.sv
// Streaming |X|^2 peak detector over one transform frame, three-stage pipeline.
module fft_peak_finder #(
  parameter int N_BINS  = 1024,
  parameter int DW      = 16,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 511
) (
  input logic              clk,
  input logic              reset,
  fft_peak_finder_if.slave bus
);
  import fft_pkg::mag_t;
  import fft_pkg::bin_t;
  import fft_pkg::peak_state_t;
  import fft_pkg::IDLE;
  import fft_pkg::RUN;
  import fft_pkg::inWindow;

  localparam int            KW     = $clog2(N_BINS/2);
  localparam logic [KW-1:0] LAST_K = KW'(N_BINS/2 - 1);

  peak_state_t   r_state;
  logic [KW-1:0] r_k;
  logic          r_tag;
  logic          r_killTag;
  logic [1:0]    r_killCnt;
  logic          r_frameAbort;

  logic          w_last;
  logic          w_abort;
  logic          w_accept;

  assign w_last   = (r_state == RUN) && (r_k == LAST_K);
  assign w_abort  = (r_state == RUN) && bus.next_out && !w_last;
  assign w_accept = (r_state == RUN) && !w_abort;

  // The tag flips at every frame start; an abort marks the old tag for removal
  // long enough for its in-flight entries to drain out of S1/S2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_tag        <= 1'b0;
      r_killTag    <= 1'b0;
      r_killCnt    <= '0;
      r_frameAbort <= 1'b0;
    end else begin
      if (r_killCnt != 2'd0) r_killCnt <= r_killCnt - 2'd1;
      if (bus.next_out) begin
        r_state <= RUN;
        r_k     <= '0;
        r_tag   <= ~r_tag;
        if (w_abort) begin
          r_frameAbort <= 1'b1;
          r_killTag    <= r_tag;
          r_killCnt    <= 2'd2;
        end
      end else if (r_state == RUN) begin
        if (w_last) begin
          r_state <= IDLE;
          r_k     <= '0;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  logic          r_s1Valid;
  logic          r_s1Tag;
  logic          r_s1First;
  logic          r_s1Last;
  logic [KW-1:0] r_s1K;
  mag_t          w_mag0;
  mag_t          w_mag1;

  cmag_sq #(.W(DW)) u_cmag0 (.clk(clk), .reset(reset), .re(bus.real0), .im(bus.imag0), .mag(w_mag0));
  cmag_sq #(.W(DW)) u_cmag1 (.clk(clk), .reset(reset), .re(bus.real1), .im(bus.imag1), .mag(w_mag1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Tag   <= 1'b0;
      r_s1First <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1K     <= '0;
    end else begin
      r_s1Valid <= w_accept;
      r_s1Tag   <= r_tag;
      r_s1First <= (r_k == '0);
      r_s1Last  <= w_last;
      r_s1K     <= r_k;
    end
  end

  bin_t w_bin0;
  bin_t w_bin1;
  mag_t w_win0;
  mag_t w_win1;
  mag_t w_pairMag;
  bin_t w_pairBin;
  logic w_kill1;

  // Out-of-window bins become zero; the even bin keeps ties.
  always_comb begin
    w_bin0 = bin_t'({r_s1K, 1'b0});
    w_bin1 = bin_t'({r_s1K, 1'b1});
    w_win0 = inWindow(w_bin0, MIN_BIN, MAX_BIN) ? w_mag0 : '0;
    w_win1 = inWindow(w_bin1, MIN_BIN, MAX_BIN) ? w_mag1 : '0;
    if (w_win1 > w_win0) begin
      w_pairMag = w_win1;
      w_pairBin = w_bin1;
    end else begin
      w_pairMag = w_win0;
      w_pairBin = w_bin0;
    end
  end

  assign w_kill1 = (r_killCnt != 2'd0) && (r_s1Tag == r_killTag);

  logic r_s2Valid;
  logic r_s2Tag;
  logic r_s2First;
  logic r_s2Last;
  mag_t r_s2Mag;
  bin_t r_s2Bin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2Valid <= 1'b0;
      r_s2Tag   <= 1'b0;
      r_s2First <= 1'b0;
      r_s2Last  <= 1'b0;
      r_s2Mag   <= '0;
      r_s2Bin   <= '0;
    end else begin
      r_s2Valid <= r_s1Valid && !w_kill1;
      r_s2Tag   <= r_s1Tag;
      r_s2First <= r_s1First;
      r_s2Last  <= r_s1Last;
      r_s2Mag   <= w_pairMag;
      r_s2Bin   <= w_pairBin;
    end
  end

  mag_t r_runMag;
  bin_t r_runBin;
  mag_t r_peakMag;
  bin_t r_peakBin;
  logic r_peakValid;
  logic w_use;
  mag_t w_baseMag;
  bin_t w_baseBin;
  mag_t w_newMag;
  bin_t w_newBin;

  // The first pair of a frame compares against a fresh zero/MIN_BIN baseline.
  always_comb begin
    w_use     = r_s2Valid && !((r_killCnt != 2'd0) && (r_s2Tag == r_killTag));
    w_baseMag = r_s2First ? '0 : r_runMag;
    w_baseBin = r_s2First ? bin_t'(MIN_BIN) : r_runBin;
    if (r_s2Mag > w_baseMag) begin
      w_newMag = r_s2Mag;
      w_newBin = r_s2Bin;
    end else begin
      w_newMag = w_baseMag;
      w_newBin = w_baseBin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_runMag    <= '0;
      r_runBin    <= '0;
      r_peakMag   <= '0;
      r_peakBin   <= '0;
      r_peakValid <= 1'b0;
    end else begin
      r_peakValid <= 1'b0;
      if (w_use) begin
        r_runMag <= w_newMag;
        r_runBin <= w_newBin;
        if (r_s2Last) begin
          r_peakMag   <= w_newMag;
          r_peakBin   <= w_newBin;
          r_peakValid <= 1'b1;
        end
      end
    end
  end

  assign bus.peak_bin    = r_peakBin;
  assign bus.peak_mag    = r_peakMag;
  assign bus.peak_valid  = r_peakValid;
  assign bus.frame_abort = r_frameAbort;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: hand-computed peaks, timing, abort and reset.
module tb_fft_peak_finder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  fft_peak_finder_if #(.DW(16)) bus ();

  fft_peak_finder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] reBins [1024];
  logic signed [15:0] imBins [1024];

  int   pvCount = 0;
  int   pvCycArr [16];
  int   pvBinArr [16];
  logic [31:0] pvMagArr [16];

  // Log every peak_valid pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.peak_valid) begin
      if (pvCount < 16) begin
        pvCycArr[pvCount] <= cyc;
        pvBinArr[pvCount] <= int'(bus.peak_bin);
        pvMagArr[pvCount] <= bus.peak_mag;
      end
      pvCount <= pvCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic checkPulse(input string tag, input int idx, input int expCyc, input int expBin, input logic [31:0] expMag);
    checkOutput({tag, "_cycle"}, 64'(pvCycArr[idx]), 64'(expCyc));
    checkOutput({tag, "_bin"}, 64'(pvBinArr[idx]), 64'(expBin));
    checkOutput({tag, "_mag"}, 64'(pvMagArr[idx]), 64'(expMag));
  endtask

  task automatic clearBins();
    for (int i = 0; i < 1024; i++) begin
      reBins[i] = '0;
      imBins[i] = '0;
    end
  endtask

  task automatic driveIdle();
    bus.next_out = 1'b0;
    bus.real0 = '0;
    bus.imag0 = '0;
    bus.real1 = '0;
    bus.imag1 = '0;
  endtask

  // Strobe next_out in the current cycle, then present 512 bin pairs.
  // abortAt >= 0 re-strobes next_out at that pair; chain re-strobes on the last pair.
  task automatic applyStimulus(input int abortAt, input bit chain, output int tStart);
    bus.next_out = 1'b1;
    tStart = cyc;
    @(posedge clk); #1;
    bus.next_out = 1'b0;
    for (int p = 0; p < 512; p++) begin
      bus.real0 = reBins[2*p];
      bus.imag0 = imBins[2*p];
      bus.real1 = reBins[2*p+1];
      bus.imag1 = imBins[2*p+1];
      if (p == abortAt || (p == 511 && chain)) begin
        bus.next_out = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    driveIdle();
  endtask

  int tA, tB, t1, t2, tC;
  int base;

  initial begin
    driveIdle();
    clearBins();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_peak_bin", 64'(bus.peak_bin), 64'd0);
    checkOutput("rst_peak_mag", 64'(bus.peak_mag), 64'd0);
    checkOutput("rst_peak_valid", 64'(bus.peak_valid), 64'd0);
    checkOutput("rst_frame_abort", 64'(bus.frame_abort), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] single tone at bin 37");
    clearBins();
    reBins[37] = 16'sd1000;
    applyStimulus(-1, 1'b0, tA);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("tone_count", 64'(pvCount), 64'd1);
    checkPulse("tone", 0, tA + 515, 37, 32'd1000000);
    checkOutput("tone_held_bin", 64'(bus.peak_bin), 64'd37);

    $display("[TB] tie inside pair 10/11");
    clearBins();
    reBins[10] = -16'sd300; imBins[10] = 16'sd400;
    reBins[11] = -16'sd300; imBins[11] = 16'sd400;
    applyStimulus(-1, 1'b0, tA);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("tie_count", 64'(pvCount), 64'd2);
    checkPulse("tie", 1, tA + 515, 10, 32'd250000);

    $display("[TB] window exclusion");
    clearBins();
    reBins[0] = 16'sd32767;
    reBins[600] = 16'sd32767;
    reBins[5] = 16'sd3; imBins[5] = 16'sd4;
    applyStimulus(-1, 1'b0, tA);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("win_count", 64'(pvCount), 64'd3);
    checkPulse("win", 2, tA + 515, 5, 32'd25);

    $display("[TB] all-zero frame");
    clearBins();
    applyStimulus(-1, 1'b0, tA);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("zero_count", 64'(pvCount), 64'd4);
    checkPulse("zero", 3, tA + 515, 1, 32'd0);

    $display("[TB] extreme values at bin 200");
    clearBins();
    reBins[200] = -16'sd32768; imBins[200] = -16'sd32768;
    applyStimulus(-1, 1'b0, tA);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("ext_count", 64'(pvCount), 64'd5);
    checkPulse("ext", 4, tA + 515, 200, 32'h8000_0000);

    $display("[TB] abort at pair 100, then frame B");
    clearBins();
    reBins[50] = 16'sd20000;
    reBins[199] = 16'sd30000;
    reBins[200] = 16'sd30000;
    applyStimulus(100, 1'b0, tA);
    clearBins();
    reBins[77] = 16'sd500; imBins[77] = 16'sd500;
    applyStimulus(-1, 1'b0, tB);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_flag", 64'(bus.frame_abort), 64'd1);
    checkOutput("abort_start", 64'(tB), 64'(tA + 101));
    checkOutput("abort_count", 64'(pvCount), 64'd6);
    checkPulse("abortB", 5, tB + 515, 77, 32'd500000);

    $display("[TB] back-to-back frames");
    clearBins();
    reBins[3] = 16'sd100;
    applyStimulus(-1, 1'b1, t1);
    clearBins();
    imBins[400] = 16'sd200;
    applyStimulus(-1, 1'b0, t2);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2b_count", 64'(pvCount), 64'd8);
    checkPulse("b2b_first", 6, t1 + 515, 3, 32'd10000);
    checkPulse("b2b_second", 7, t1 + 1027, 400, 32'd40000);
    checkOutput("abort_sticky", 64'(bus.frame_abort), 64'd1);

    $display("[TB] reset mid-frame");
    clearBins();
    reBins[300] = 16'sd1000;
    bus.next_out = 1'b1;
    tC = cyc;
    @(posedge clk); #1;
    bus.next_out = 1'b0;
    for (int p = 0; p < 200; p++) begin
      bus.real0 = reBins[2*p];
      bus.imag0 = imBins[2*p];
      bus.real1 = reBins[2*p+1];
      bus.imag1 = imBins[2*p+1];
      @(posedge clk); #1;
    end
    base = pvCount;
    reset = 1'b1;
    #1;
    checkOutput("rst2_peak_bin", 64'(bus.peak_bin), 64'd0);
    checkOutput("rst2_peak_mag", 64'(bus.peak_mag), 64'd0);
    checkOutput("rst2_peak_valid", 64'(bus.peak_valid), 64'd0);
    checkOutput("rst2_frame_abort", 64'(bus.frame_abort), 64'd0);
    driveIdle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    checkOutput("rst2_no_stale_pulse", 64'(pvCount), 64'(base));
    checkOutput("rst2_bin_after", 64'(bus.peak_bin), 64'd0);
    checkOutput("rst2_frame_len", 64'(cyc - tC > 515), 64'd1);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
